axictrl_arb_ctrl: RTL and testbench
===================================

Name: axictrl_arb_ctrl

Overview:
- Parametrised channel-ownership controller for the AXI bus0 crossbar.
- Arbitrates AR and AW requests from MST_TOTAL masters, round-robin or fixed priority.
- Decodes the target slave from per-slave base/mask inputs and tracks which master/slave pair owns the AR/R, AW/W and B channels.
- Lets a new AW phase overlap a pending B response. The crossbar datapath uses its index outputs as mux selects.

Parameters:
- MST_TOTAL, 4, number of masters (2..16)
- SLV_TOTAL, 4, number of address-decoded slaves (1..16); index SLV_TOTAL is the decode-error sink
- ADDR_BITS, 48, address width
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest master index wins
- MIDX_W, $clog2(MST_TOTAL+1), master index width
- SIDX_W, $clog2(SLV_TOTAL+1), slave index width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_slv_base  in  SLV_TOTAL*ADDR_BITS  slave base addresses
- i_slv_mask  in  SLV_TOTAL*ADDR_BITS  slave address masks
- i_ar_valid  in  MST_TOTAL  AR request per master
- i_ar_addr  in  MST_TOTAL*ADDR_BITS  AR address per master
- i_ar_hs  in  1  forwarded AR accepted by slave or decode-error sink
- i_r_last_hs  in  1  final R beat accepted by master
- i_aw_valid  in  MST_TOTAL  AW request per master
- i_aw_addr  in  MST_TOTAL*ADDR_BITS  AW address per master
- i_aw_hs  in  1  forwarded AW accepted
- i_w_last_hs  in  1  final W beat accepted by slave
- i_b_hs  in  1  B response accepted by master
- o_ar_grant  out  MST_TOTAL  one-hot AR grant; zero when no grant
- o_r_midx  out  MIDX_W  owning master, read path
- o_r_sidx  out  SIDX_W  owning slave, read path
- o_r_busy  out  1  read path owned
- o_aw_grant  out  MST_TOTAL  one-hot AW grant
- o_w_midx  out  MIDX_W  owning master, write path
- o_w_sidx  out  SIDX_W  owning slave, write path
- o_w_busy  out  1  write path owned
- o_wlast_allow  out  1  final W beat may be forwarded
- o_b_midx  out  MIDX_W  master receiving B
- o_b_sidx  out  SIDX_W  slave returning B
- o_b_busy  out  1  B pending

Behaviour:
- Reset:
  - Both FSMs go to IDLE.
  - All midx outputs = MST_TOTAL; all sidx outputs = SLV_TOTAL.
  - Busy outputs = 0, grants = 0.
  - Both round-robin pointers = MST_TOTAL-1.
  - Reset asserted mid-transfer aborts ownership immediately. No handshake is replayed.
- Decode:
  - Slave s matches when (addr & mask_s) == (base_s & mask_s).
  - If several slaves match, the lowest s wins.
  - No match gives sidx = SLV_TOTAL (decode-error sink).
- Arbitration (RR_EN=1):
  - Search masters starting at ptr+1 modulo MST_TOTAL; the first master with valid set wins.
  - The pointer updates to the winner when its transaction completes.
  - RR_EN=0: the lowest valid index wins and the pointer is unused.
- Read FSM, IDLE -> ADDR -> DATA:
  - IDLE: if any i_ar_valid, register winner into r_midx and its decoded slave into r_sidx, set busy, go ADDR. Latency is one cycle from valid to grant.
  - ADDR: o_ar_grant[r_midx]=1. On i_ar_hs, go DATA and drop the grant.
  - DATA: on i_r_last_hs, go IDLE, reload idle indices and clear busy. A new arbitration may happen no earlier than the following cycle.
  - i_ar_hs outside ADDR and i_r_last_hs outside DATA are ignored.
- Write FSM, IDLE -> ADDR -> DATA:
  - IDLE and ADDR behave as for read, using the AW signals and the w indices.
  - DATA: o_wlast_allow = !o_b_busy || i_b_hs.
  - On i_w_last_hs with o_wlast_allow=1: copy w_midx/w_sidx into b_midx/b_sidx, set b_busy, and return the write FSM to IDLE.
  - i_w_last_hs while o_wlast_allow=0 is a protocol error; it is ignored and covered by an assertion.
- B slot:
  - On i_b_hs: clear b_busy and restore b indices to idle values, unless a same-cycle w-last transfer reloads them. The reload has priority.
  - A new AW may be arbitrated and granted while b_busy=1 (overlap).
- Read and write paths are fully independent. The same master may own both at once.

Test Plan:
- Reset → grants 0, r/w/b midx=4, sidx=4, busy 0 (defaults). Release reset, no valids for 10 cycles → outputs unchanged.
- Single read, master 2, address matching slave 1 → cycle+1: o_ar_grant=4'b0100, r_sidx=1. i_ar_hs → grant 0. i_r_last_hs → r_busy 0, r_midx=4.
- Round-robin: masters 0 and 3 hold AR valid continuously → grants in order 0,3,0,3 over four transactions. With RR_EN=0 → 0,0,0,0.
- Decode error: AW address matching no slave → w_sidx=4, w_busy 1. Completion moves b_sidx=4.
- Overlap, B pending for master 1:
  - AW from master 2 is granted while b_busy=1; o_wlast_allow=0 until i_b_hs.
  - i_b_hs and i_w_last_hs in the same cycle → b_midx=2, b_busy stays 1.
- Reset mid-read (state DATA) → next cycle IDLE, r_busy 0; a pending AR is re-arbitrated after reset release.

Source files
------------

// File: rtl/axictrl_arb_ctrl_if.sv
// Bus bundle between the crossbar datapath and the ownership controller.
// slave: controller side (requests/handshakes in, grants/indices out); master: driver side.
interface axictrl_arb_ctrl_if #(
    parameter int MST_TOTAL = 4,
    parameter int SLV_TOTAL = 4,
    parameter int ADDR_BITS = 48,
    parameter int MIDX_W    = $clog2(MST_TOTAL + 1),
    parameter int SIDX_W    = $clog2(SLV_TOTAL + 1)
);
    logic [SLV_TOTAL*ADDR_BITS-1:0] i_slv_base;
    logic [SLV_TOTAL*ADDR_BITS-1:0] i_slv_mask;
    logic [MST_TOTAL-1:0]           i_ar_valid;
    logic [MST_TOTAL*ADDR_BITS-1:0] i_ar_addr;
    logic                           i_ar_hs;
    logic                           i_r_last_hs;
    logic [MST_TOTAL-1:0]           i_aw_valid;
    logic [MST_TOTAL*ADDR_BITS-1:0] i_aw_addr;
    logic                           i_aw_hs;
    logic                           i_w_last_hs;
    logic                           i_b_hs;
    logic [MST_TOTAL-1:0]           o_ar_grant;
    logic [MIDX_W-1:0]              o_r_midx;
    logic [SIDX_W-1:0]              o_r_sidx;
    logic                           o_r_busy;
    logic [MST_TOTAL-1:0]           o_aw_grant;
    logic [MIDX_W-1:0]              o_w_midx;
    logic [SIDX_W-1:0]              o_w_sidx;
    logic                           o_w_busy;
    logic                           o_wlast_allow;
    logic [MIDX_W-1:0]              o_b_midx;
    logic [SIDX_W-1:0]              o_b_sidx;
    logic                           o_b_busy;

    modport slave (
        input  i_slv_base, i_slv_mask,
        input  i_ar_valid, i_ar_addr, i_ar_hs, i_r_last_hs,
        input  i_aw_valid, i_aw_addr, i_aw_hs, i_w_last_hs, i_b_hs,
        output o_ar_grant, o_r_midx, o_r_sidx, o_r_busy,
        output o_aw_grant, o_w_midx, o_w_sidx, o_w_busy,
        output o_wlast_allow, o_b_midx, o_b_sidx, o_b_busy
    );

    modport master (
        output i_slv_base, i_slv_mask,
        output i_ar_valid, i_ar_addr, i_ar_hs, i_r_last_hs,
        output i_aw_valid, i_aw_addr, i_aw_hs, i_w_last_hs, i_b_hs,
        input  o_ar_grant, o_r_midx, o_r_sidx, o_r_busy,
        input  o_aw_grant, o_w_midx, o_w_sidx, o_w_busy,
        input  o_wlast_allow, o_b_midx, o_b_sidx, o_b_busy
    );
endinterface

// File: rtl/axictrl_arb_ctrl.sv
// Channel-ownership controller for the bus0 crossbar: AR/AW arbitration, slave decode, B slot.
// Ports: i_clk, i_rst (async, active-high), bus (axictrl_arb_ctrl_if.slave).
module axictrl_arb_ctrl #(
    parameter int MST_TOTAL = 4,
    parameter int SLV_TOTAL = 4,
    parameter int ADDR_BITS = 48,
    parameter bit RR_EN     = 1'b1,
    parameter int MIDX_W    = $clog2(MST_TOTAL + 1),
    parameter int SIDX_W    = $clog2(SLV_TOTAL + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    axictrl_arb_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [MIDX_W-1:0] MIDX_IDLE = MIDX_W'(MST_TOTAL);
    localparam logic [SIDX_W-1:0] SIDX_IDLE = SIDX_W'(SLV_TOTAL);
    localparam logic [MIDX_W-1:0] PTR_INIT  = MIDX_W'(MST_TOTAL - 1);

    // Lowest matching slave wins, so scan from the top down.
    function automatic logic [SIDX_W-1:0] decode(
        input logic [ADDR_BITS-1:0]           addr,
        input logic [SLV_TOTAL*ADDR_BITS-1:0] base,
        input logic [SLV_TOTAL*ADDR_BITS-1:0] mask
    );
        logic [SIDX_W-1:0]    sel;
        logic [ADDR_BITS-1:0] b;
        logic [ADDR_BITS-1:0] m;
        sel = SIDX_IDLE;
        for (int s = SLV_TOTAL - 1; s >= 0; s--) begin
            b = base[s*ADDR_BITS +: ADDR_BITS];
            m = mask[s*ADDR_BITS +: ADDR_BITS];
            if ((addr & m) == (b & m))
                sel = SIDX_W'(s);
        end
        return sel;
    endfunction

    // Round-robin scans ptr+1 .. ptr (mod MST_TOTAL); fixed mode scans 0 upward.
    function automatic logic [MIDX_W-1:0] arbitrate(
        input logic [MST_TOTAL-1:0] req,
        input logic [MIDX_W-1:0]    ptr
    );
        logic [MIDX_W-1:0]    win;
        logic                 found;
        logic [MST_TOTAL-1:0] sh;
        int                   idx;
        win   = MIDX_IDLE;
        found = 1'b0;
        for (int k = 1; k <= MST_TOTAL; k++) begin
            if (RR_EN) begin
                idx = int'(ptr) + k;
                if (idx >= MST_TOTAL)
                    idx = idx - MST_TOTAL;
            end else begin
                idx = k - 1;
            end
            sh = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = MIDX_W'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [ADDR_BITS-1:0] pick_addr(
        input logic [MST_TOTAL*ADDR_BITS-1:0] addrs,
        input logic [MIDX_W-1:0]              idx
    );
        return ADDR_BITS'(addrs >> (int'(idx) * ADDR_BITS));
    endfunction

    logic [1:0]        r_state, w_state;
    logic [MIDX_W-1:0] r_midx, w_midx, b_midx;
    logic [SIDX_W-1:0] r_sidx, w_sidx, b_sidx;
    logic              r_busy, w_busy, b_busy;
    logic [MIDX_W-1:0] r_ptr, w_ptr;

    logic [MIDX_W-1:0] ar_win, aw_win;
    logic [SIDX_W-1:0] ar_dec, aw_dec;
    logic              wlast_allow;
    logic              w_done;

    always_comb begin
        ar_win = arbitrate(bus.i_ar_valid, r_ptr);
        aw_win = arbitrate(bus.i_aw_valid, w_ptr);
        ar_dec = decode(pick_addr(bus.i_ar_addr, ar_win),
                        bus.i_slv_base, bus.i_slv_mask);
        aw_dec = decode(pick_addr(bus.i_aw_addr, aw_win),
                        bus.i_slv_base, bus.i_slv_mask);
    end

    // The final W beat may only go once the B slot is free or freeing now.
    assign wlast_allow = (w_state == DATA) && (!b_busy || bus.i_b_hs);
    assign w_done      = (w_state == DATA) && bus.i_w_last_hs && wlast_allow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_midx  <= MIDX_IDLE;
            r_sidx  <= SIDX_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= PTR_INIT;
        end else begin
            case (r_state)
                IDLE: if (|bus.i_ar_valid) begin
                    r_midx  <= ar_win;
                    r_sidx  <= ar_dec;
                    r_busy  <= 1'b1;
                    r_state <= ADDR;
                end
                ADDR: if (bus.i_ar_hs) r_state <= DATA;
                DATA: if (bus.i_r_last_hs) begin
                    r_state <= IDLE;
                    r_midx  <= MIDX_IDLE;
                    r_sidx  <= SIDX_IDLE;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_midx;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_state <= IDLE;
            w_midx  <= MIDX_IDLE;
            w_sidx  <= SIDX_IDLE;
            w_busy  <= 1'b0;
            w_ptr   <= PTR_INIT;
        end else begin
            case (w_state)
                IDLE: if (|bus.i_aw_valid) begin
                    w_midx  <= aw_win;
                    w_sidx  <= aw_dec;
                    w_busy  <= 1'b1;
                    w_state <= ADDR;
                end
                ADDR: if (bus.i_aw_hs) w_state <= DATA;
                DATA: if (w_done) begin
                    w_state <= IDLE;
                    w_midx  <= MIDX_IDLE;
                    w_sidx  <= SIDX_IDLE;
                    w_busy  <= 1'b0;
                    w_ptr   <= w_midx;
                end
                default: w_state <= IDLE;
            endcase
        end
    end

    // A same-cycle hand-off from the write path outranks the B release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            b_midx <= MIDX_IDLE;
            b_sidx <= SIDX_IDLE;
            b_busy <= 1'b0;
        end else if (w_done) begin
            b_midx <= w_midx;
            b_sidx <= w_sidx;
            b_busy <= 1'b1;
        end else if (b_busy && bus.i_b_hs) begin
            b_midx <= MIDX_IDLE;
            b_sidx <= SIDX_IDLE;
            b_busy <= 1'b0;
        end
    end

    always_comb begin
        bus.o_ar_grant = '0;
        bus.o_aw_grant = '0;
        for (int m = 0; m < MST_TOTAL; m++) begin
            if (r_state == ADDR && r_midx == MIDX_W'(m))
                bus.o_ar_grant[m] = 1'b1;
            if (w_state == ADDR && w_midx == MIDX_W'(m))
                bus.o_aw_grant[m] = 1'b1;
        end
    end

    assign bus.o_r_midx      = r_midx;
    assign bus.o_r_sidx      = r_sidx;
    assign bus.o_r_busy      = r_busy;
    assign bus.o_w_midx      = w_midx;
    assign bus.o_w_sidx      = w_sidx;
    assign bus.o_w_busy      = w_busy;
    assign bus.o_wlast_allow = wlast_allow;
    assign bus.o_b_midx      = b_midx;
    assign bus.o_b_sidx      = b_sidx;
    assign bus.o_b_busy      = b_busy;

    // Final W beat while the B slot is still occupied is a protocol error.
    wlast_proto_a: assert property (
        @(posedge i_clk) disable iff (i_rst)
        !((w_state == DATA) && bus.i_w_last_hs && !wlast_allow)
    );
endmodule

// File: tb/tb_axictrl_arb_ctrl.sv
// Directed bench for axictrl_arb_ctrl: round-robin and fixed-priority instances.
// Grant order is checked through expected-grant queues; other points are direct checks.
module tb_axictrl_arb_ctrl;
    localparam int MST = 4;
    localparam int SLV = 4;
    localparam int AB  = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [MST-1:0] q_rr[$];
    logic [MST-1:0] q_fx[$];

    always #5 clk = ~clk;

    axictrl_arb_ctrl_if #(.MST_TOTAL(MST), .SLV_TOTAL(SLV), .ADDR_BITS(AB)) bus0 ();
    axictrl_arb_ctrl_if #(.MST_TOTAL(MST), .SLV_TOTAL(SLV), .ADDR_BITS(AB)) bus1 ();

    axictrl_arb_ctrl #(
        .MST_TOTAL(MST), .SLV_TOTAL(SLV), .ADDR_BITS(AB), .RR_EN(1'b1)
    ) dut_rr (
        .i_clk(clk), .i_rst(rst), .bus(bus0)
    );

    axictrl_arb_ctrl #(
        .MST_TOTAL(MST), .SLV_TOTAL(SLV), .ADDR_BITS(AB), .RR_EN(1'b0)
    ) dut_fx (
        .i_clk(clk), .i_rst(rst), .bus(bus1)
    );

    // The fixed-priority instance sees exactly the same stimulus.
    assign bus1.i_slv_base  = bus0.i_slv_base;
    assign bus1.i_slv_mask  = bus0.i_slv_mask;
    assign bus1.i_ar_valid  = bus0.i_ar_valid;
    assign bus1.i_ar_addr   = bus0.i_ar_addr;
    assign bus1.i_ar_hs     = bus0.i_ar_hs;
    assign bus1.i_r_last_hs = bus0.i_r_last_hs;
    assign bus1.i_aw_valid  = bus0.i_aw_valid;
    assign bus1.i_aw_addr   = bus0.i_aw_addr;
    assign bus1.i_aw_hs     = bus0.i_aw_hs;
    assign bus1.i_w_last_hs = bus0.i_w_last_hs;
    assign bus1.i_b_hs      = bus0.i_b_hs;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ar(input string tag);
        int n;
        n = 0;
        while (bus0.o_ar_grant == '0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: no AR grant within 20 cycles", tag);
        end
        chk({tag, "_rr"}, 64'(bus0.o_ar_grant), 64'(q_rr.pop_front()));
        chk({tag, "_fx"}, 64'(bus1.o_ar_grant), 64'(q_fx.pop_front()));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ar_grant"}, 64'(bus0.o_ar_grant), 64'(0));
        chk({tag, "_aw_grant"}, 64'(bus0.o_aw_grant), 64'(0));
        chk({tag, "_r_midx"}, 64'(bus0.o_r_midx), 64'(4));
        chk({tag, "_r_sidx"}, 64'(bus0.o_r_sidx), 64'(4));
        chk({tag, "_w_midx"}, 64'(bus0.o_w_midx), 64'(4));
        chk({tag, "_w_sidx"}, 64'(bus0.o_w_sidx), 64'(4));
        chk({tag, "_b_midx"}, 64'(bus0.o_b_midx), 64'(4));
        chk({tag, "_b_sidx"}, 64'(bus0.o_b_sidx), 64'(4));
        chk({tag, "_busy"}, 64'({bus0.o_r_busy, bus0.o_w_busy,
                                 bus0.o_b_busy}), 64'(0));
    endtask

    // Write phase from one master up to the AW handshake (write FSM in DATA).
    task automatic aw_phase(input int m, input logic [AB-1:0] a);
        bus0.i_aw_valid    = '0;
        bus0.i_aw_valid[m] = 1'b1;
        bus0.i_aw_addr[m*AB +: AB] = a;
        tick();
        chk("aw_grant", 64'(bus0.o_aw_grant), 64'(1) << m);
        bus0.i_aw_valid = '0;
        bus0.i_aw_hs    = 1'b1;
        tick();
        bus0.i_aw_hs = 1'b0;
    endtask

    initial begin
        bus0.i_ar_valid  = '0;
        bus0.i_ar_addr   = '0;
        bus0.i_ar_hs     = 1'b0;
        bus0.i_r_last_hs = 1'b0;
        bus0.i_aw_valid  = '0;
        bus0.i_aw_addr   = '0;
        bus0.i_aw_hs     = 1'b0;
        bus0.i_w_last_hs = 1'b0;
        bus0.i_b_hs      = 1'b0;
        for (int s = 0; s < SLV; s++) begin
            bus0.i_slv_base[s*AB +: AB] = {8'(s + 1), 40'h0};
            bus0.i_slv_mask[s*AB +: AB] = 48'hFF00_0000_0000;
        end

        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_idle("quiet");

        // Single read: master 2 to slave 1.
        bus0.i_ar_valid[2] = 1'b1;
        bus0.i_ar_addr[2*AB +: AB] = 48'h0200_0000_1234;
        tick();
        chk("rd_grant", 64'(bus0.o_ar_grant), 64'b0100);
        chk("rd_midx", 64'(bus0.o_r_midx), 64'(2));
        chk("rd_sidx", 64'(bus0.o_r_sidx), 64'(1));
        chk("rd_busy", 64'(bus0.o_r_busy), 64'(1));
        bus0.i_ar_valid = '0;
        bus0.i_ar_hs    = 1'b1;
        tick();
        bus0.i_ar_hs = 1'b0;
        chk("rd_grant_drop", 64'(bus0.o_ar_grant), 64'(0));
        chk("rd_busy_data", 64'(bus0.o_r_busy), 64'(1));
        bus0.i_r_last_hs = 1'b1;
        tick();
        bus0.i_r_last_hs = 1'b0;
        chk("rd_done_busy", 64'(bus0.o_r_busy), 64'(0));
        chk("rd_done_midx", 64'(bus0.o_r_midx), 64'(4));
        chk("rd_done_sidx", 64'(bus0.o_r_sidx), 64'(4));

        // Round robin vs fixed priority: masters 0 and 3 keep requesting.
        // RR pointer was 2 after the last read, so master 3 goes first.
        bus0.i_ar_addr[0*AB +: AB] = 48'h0100_0000_0000;
        bus0.i_ar_addr[3*AB +: AB] = 48'h0100_0000_0040;
        bus0.i_ar_valid = 4'b1001;
        q_rr.push_back(4'b1000);
        q_rr.push_back(4'b0001);
        q_rr.push_back(4'b1000);
        q_rr.push_back(4'b0001);
        for (int i = 0; i < 4; i++) q_fx.push_back(4'b0001);
        for (int i = 0; i < 4; i++) begin
            wait_ar($sformatf("rr%0d", i));
            bus0.i_ar_hs = 1'b1;
            tick();
            bus0.i_ar_hs     = 1'b0;
            bus0.i_r_last_hs = 1'b1;
            tick();
            bus0.i_r_last_hs = 1'b0;
        end
        bus0.i_ar_valid = '0;
        tick();
        chk("rr_idle", 64'(bus0.o_r_busy), 64'(0));

        // Decode error on the write path, then drain through the B slot.
        aw_phase(0, 48'h0500_0000_0000);
        chk("de_w_sidx", 64'(bus0.o_w_sidx), 64'(4));
        chk("de_w_busy", 64'(bus0.o_w_busy), 64'(1));
        chk("de_allow", 64'(bus0.o_wlast_allow), 64'(1));
        bus0.i_w_last_hs = 1'b1;
        tick();
        bus0.i_w_last_hs = 1'b0;
        chk("de_b_sidx", 64'(bus0.o_b_sidx), 64'(4));
        chk("de_b_midx", 64'(bus0.o_b_midx), 64'(0));
        chk("de_b_busy", 64'(bus0.o_b_busy), 64'(1));
        chk("de_w_free", 64'(bus0.o_w_busy), 64'(0));
        bus0.i_b_hs = 1'b1;
        tick();
        bus0.i_b_hs = 1'b0;
        chk("de_b_clear", 64'(bus0.o_b_busy), 64'(0));
        chk("de_b_idle", 64'(bus0.o_b_midx), 64'(4));

        // Overlap: B pending for master 1 while master 2 writes.
        aw_phase(1, 48'h0300_0000_0000);
        bus0.i_w_last_hs = 1'b1;
        tick();
        bus0.i_w_last_hs = 1'b0;
        chk("ov_b_midx1", 64'(bus0.o_b_midx), 64'(1));
        chk("ov_b_sidx1", 64'(bus0.o_b_sidx), 64'(2));
        aw_phase(2, 48'h0400_0000_0000);
        chk("ov_b_held", 64'(bus0.o_b_busy), 64'(1));
        chk("ov_w_sidx", 64'(bus0.o_w_sidx), 64'(3));
        chk("ov_block", 64'(bus0.o_wlast_allow), 64'(0));
        tick();
        chk("ov_block2", 64'(bus0.o_wlast_allow), 64'(0));
        bus0.i_b_hs      = 1'b1;
        bus0.i_w_last_hs = 1'b1;
        #1;
        chk("ov_allow", 64'(bus0.o_wlast_allow), 64'(1));
        tick();
        bus0.i_b_hs      = 1'b0;
        bus0.i_w_last_hs = 1'b0;
        chk("ov_b_midx2", 64'(bus0.o_b_midx), 64'(2));
        chk("ov_b_sidx2", 64'(bus0.o_b_sidx), 64'(3));
        chk("ov_b_busy", 64'(bus0.o_b_busy), 64'(1));
        chk("ov_w_free", 64'(bus0.o_w_busy), 64'(0));
        bus0.i_b_hs = 1'b1;
        tick();
        bus0.i_b_hs = 1'b0;
        chk("ov_b_clear", 64'(bus0.o_b_busy), 64'(0));

        // Reset during read DATA; pending AR is re-arbitrated afterwards.
        bus0.i_ar_addr[1*AB +: AB] = 48'h0200_0000_0000;
        bus0.i_ar_valid = 4'b0010;
        tick();
        bus0.i_ar_hs = 1'b1;
        tick();
        bus0.i_ar_hs = 1'b0;
        chk("mr_busy", 64'(bus0.o_r_busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("mr_abort_busy", 64'(bus0.o_r_busy), 64'(0));
        chk("mr_abort_midx", 64'(bus0.o_r_midx), 64'(4));
        tick();
        rst = 1'b0;
        tick();
        chk("mr_regrant", 64'(bus0.o_ar_grant), 64'b0010);
        chk("mr_midx", 64'(bus0.o_r_midx), 64'(1));
        chk("mr_sidx", 64'(bus0.o_r_sidx), 64'(1));
        bus0.i_ar_valid = '0;
        bus0.i_ar_hs    = 1'b1;
        tick();
        bus0.i_ar_hs     = 1'b0;
        bus0.i_r_last_hs = 1'b1;
        tick();
        bus0.i_r_last_hs = 1'b0;
        check_idle("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
